// File: rtl/gf256_pkg.sv
// Shared GF(2^8) definitions for the RS decoder arithmetic blocks.
// Field width, reduction polynomial, inverse schedule and divider states.
package gf256_pkg;

  localparam int GF_W = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int INV_SQR_STEPS = 6;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MULB,
    FSQR,
    MULA,
    DONE
  } state_t;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, x = a * b mod GF_POLY.
// Shift-and-add with per-step reduction by the low polynomial bits.
module gf256_mul
  import gf256_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic [GF_W-1:0] x
);

  logic [GF_W-1:0] acc;
  logic [GF_W-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[GF_W-2:0], 1'b0}
         ^ (sh[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    end
    x = acc;
  end

endmodule

// File: rtl/gf256_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254 on one shared multiplier.
// Fixed 14-cycle latency from accept to out_valid, valid/ready both sides.
module gf256_div_seq
  import gf256_pkg::*;
#(
  parameter logic [7:0] DIV0_VALUE = 8'h00,
  parameter int SQR_STEPS = INV_SQR_STEPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic       div_by_zero
);

  localparam logic [2:0] CNT_LAST = 3'(SQR_STEPS - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [7:0] r;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       dz;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] prod;

  gf256_mul u_mul (
    .a (op_a),
    .b (op_b),
    .x (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand muxes depend on state only, never on the live inputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    op_a      = r;
    op_b      = r;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SQR;
      end
      SQR:  state_nx = MULB;
      MULB: begin
        op_b     = b_q;
        state_nx = (cnt == CNT_LAST) ? FSQR : SQR;
      end
      FSQR: state_nx = MULA;
      MULA: begin
        op_b     = a_q;
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      q           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            r   <= b;
            cnt <= '0;
            dz  <= (b == 8'h00);
          end
        end
        SQR, FSQR: r <= prod;
        MULB: begin
          r   <= prod;
          cnt <= cnt + 3'd1;
        end
        MULA: begin
          q           <= dz ? DIV0_VALUE : prod;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf256_div_seq.sv
// Randomized self-checking bench for gf256_div_seq.
// Reference: polynomial product mod 0x11D and brute-force inverse search.
module tb_gf256_div_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  gf256_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) p = p ^ (16'(x) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] y);
    logic [7:0] res;
    res = 8'h00;
    for (int x = 1; x < 256; x++)
      if (ref_mul(y, 8'(x)) == 8'h01) res = 8'(x);
    return res;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y);
    if (y == 8'h00) return 8'h00;
    return ref_mul(x, ref_inv(y));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                        input int hold, input bit keep_valid,
                        output logic [7:0] rq);
    int n;
    int lat;
    bit stable;
    logic [7:0] exp_q;
    exp_q = ref_div(ta, tb);
    rq = 8'hxx;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = keep_valid;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rq = q;
    chk("latency", lat, 14);
    chk("q", q, exp_q);
    chk("dz", div_by_zero, tb == 8'h00);
    chk("busy_ready", in_ready, 0);
    if (tb != 8'h00) chk("q_times_b", ref_mul(q, tb), ta);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      a = 8'($urandom);
      if (!out_valid || q !== exp_q || in_ready ||
          div_by_zero !== (tb == 8'h00)) stable = 1'b0;
    end
    if (hold > 0) chk("hold", stable, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] rq;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_q", q, 8'h00);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("quiet_after_rst", seen, 0);

    run_op(8'h01, 8'h02, 0, 1'b0, rq);
    chk("inv2", rq, 8'h8E);
    run_op(8'h8E, 8'h8E, 0, 1'b0, rq);
    chk("a_eq_b", rq, 8'h01);
    run_op(8'h37, 8'h01, 2, 1'b0, rq);
    chk("b_one", rq, 8'h37);
    run_op(8'h05, 8'h00, 0, 1'b0, rq);
    chk("div0", rq, 8'h00);
    run_op(8'h05, 8'h01, 0, 1'b0, rq);
    chk("after_div0", rq, 8'h05);
    run_op(8'hA5, 8'h3C, 20, 1'b1, rq);

    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h44;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_valid", seen, 0);
    run_op(8'h02, 8'h8E, 0, 1'b0, rq);
    chk("post_rst_op", rq, 8'h04);

    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(8'(i), 8'($urandom_range(1, 255)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
